// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
//
// Shared definitions for the UART transmit arbiter:
//   - arb_state_e : FSM state encoding (IDLE, START, WAIT_LOW, WAIT_HIGH)
//   - *_DEF       : default parameter values for the arbiter
//   - cnt_width() : width of the accept-timeout counter, clog2(TIMEOUT)
//   - idx_width() : width of a requester index, clog2(NREQ)
// -----------------------------------------------------------------------------
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } arb_state_e;

    localparam int NREQ_DEF    = 4;
    localparam int NBITS_DEF   = 8;
    localparam int TIMEOUT_DEF = 16;

    localparam int CNT_W_DEF   = $clog2(TIMEOUT_DEF);

    // The counter only has to hold values up to TIMEOUT-1.
    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

    function automatic int idx_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/rr_priority.sv
// -----------------------------------------------------------------------------
// rr_priority
//
// Purely combinational round-robin picker. Starting at index `ptr` and
// searching upward with wrap-around, the first set bit of `req` wins.
//
// Parameters:
//   NREQ    : number of requesters
//   IDX_W   : width of an index into the request vector
// Ports:
//   req     in  [NREQ-1:0]  : eligible requests
//   ptr     in  [IDX_W-1:0] : highest-priority index this cycle
//   win     out [NREQ-1:0]  : one-hot winner, 0 when req is 0
//   win_idx out [IDX_W-1:0] : index of the winner, 0 when req is 0
// -----------------------------------------------------------------------------
module rr_priority #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  win,
    output logic [IDX_W-1:0] win_idx
);

    // Scan the offsets from farthest to nearest. Every hit overwrites the
    // previous one, so the last write is the nearest eligible index above
    // the pointer, which is exactly the round-robin winner.
    always_comb begin
        logic [IDX_W:0] pos;
        // NOTE: every variable written in a combinational block gets a
        // default first; a path that leaves one unassigned infers a latch.
        win     = '0;
        win_idx = '0;
        pos     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (pos >= (IDX_W + 1)'(NREQ)) begin
                pos = pos - (IDX_W + 1)'(NREQ);
            end
            if (req[pos[IDX_W-1:0]]) begin
                win                   = '0;
                win[pos[IDX_W-1:0]]   = 1'b1;
                win_idx               = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NREQ byte producers. A client holds
// i_req high with its byte on its i_data slice; the arbiter picks a winner
// round-robin, latches the byte, pulses the transmitter start, follows the
// transmitter's done level low (accepted) and high again (frame finished),
// and then pulses the client's ack. If the transmitter never accepts the
// start within TIMEOUT cycles, o_err pulses and the grant is dropped without
// an ack so the client retries later.
//
// Parameters:
//   NREQ    : number of requesters (2..8)
//   NBITS   : byte width
//   TIMEOUT : cycles allowed for done to drop after a start pulse
// Ports:
//   clk         in                 : clock
//   rst         in                 : asynchronous active-high reset
//   i_req       in  [NREQ-1:0]     : request levels, held until ack
//   i_data      in  [NREQ*NBITS-1] : client k's byte at [k*NBITS +: NBITS]
//   o_ack       out [NREQ-1:0]     : one-cycle pulse to the served client
//   o_grant     out [NREQ-1:0]     : one-hot transmitter owner, 0 when idle
//   o_tx_start  out                : one-cycle start pulse to the transmitter
//   o_tx_data   out [NBITS-1:0]    : latched byte, stable from grant to ack
//   i_tx_done   in                 : transmitter idle level (0 = in frame)
//   o_busy      out                : high whenever the FSM is not IDLE
//   o_err       out                : one-cycle pulse on accept timeout
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int NBITS   = NBITS_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ*NBITS-1:0] i_data,
    output logic [NREQ-1:0]       o_ack,
    output logic [NREQ-1:0]       o_grant,
    output logic                  o_tx_start,
    output logic [NBITS-1:0]      o_tx_data,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_err
);

    localparam int IDX_W = idx_width(NREQ);
    localparam int CNT_W = cnt_width(TIMEOUT);

    arb_state_e        state_q;
    arb_state_e        state_nxt;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  ptr_nxt;
    logic [IDX_W-1:0]  gidx_q;
    logic [IDX_W-1:0]  gidx_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;

    logic [NREQ-1:0]   ack_nxt;
    logic [NREQ-1:0]   grant_nxt;
    logic              start_nxt;
    logic [NBITS-1:0]  data_nxt;
    logic              err_nxt;

    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   win;
    logic [IDX_W-1:0]  win_idx;
    logic [NBITS-1:0]  win_data;
    logic              grant_now;
    logic              timeout_hit;
    logic [IDX_W-1:0]  ptr_adv;

    // A client being acked this cycle still has i_req high; masking it with
    // the registered ack keeps it from being granted a second time.
    assign eligible  = i_req & ~o_ack;

    // A grant needs an idle transmitter. After a reset mid-frame done is
    // still low, so this also holds off the first grant until it finishes.
    assign grant_now = i_tx_done && (eligible != '0);

    // The counter runs 0,1,2,... in WAIT_LOW; the timeout fires on the
    // evaluation that would increment it to TIMEOUT-1.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 2));

    // Next pointer is one past the client just served, wrapping at NREQ.
    assign ptr_adv = (gidx_q == IDX_W'(NREQ - 1)) ? '0 : gidx_q + IDX_W'(1);

    rr_priority #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_priority (
        .req     (eligible),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx)
    );

    // Byte of the current winner, selected by the one-hot vector.
    always_comb begin
        win_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win[k]) begin
                win_data = i_data[k*NBITS +: NBITS];
            end
        end
    end

    // ------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------
    // NOTE: state uses non-blocking assignments so every register in this
    // block updates from the same pre-edge values, independent of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gidx_q     <= '0;
            cnt_q      <= '0;
            o_ack      <= '0;
            o_grant    <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            ptr_q      <= ptr_nxt;
            gidx_q     <= gidx_nxt;
            cnt_q      <= cnt_nxt;
            o_ack      <= ack_nxt;
            o_grant    <= grant_nxt;
            o_tx_start <= start_nxt;
            o_tx_data  <= data_nxt;
            o_busy     <= (state_nxt != IDLE);
            o_err      <= err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_now) begin
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!i_tx_done) begin
                    state_nxt = WAIT_HIGH;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_HIGH: begin
                // No timeout here: frame length depends on the baud rate.
                if (i_tx_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        ack_nxt   = '0;
        start_nxt = 1'b0;
        err_nxt   = 1'b0;
        grant_nxt = o_grant;
        data_nxt  = o_tx_data;
        ptr_nxt   = ptr_q;
        gidx_nxt  = gidx_q;
        cnt_nxt   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (grant_now) begin
                    grant_nxt = win;
                    gidx_nxt  = win_idx;
                    data_nxt  = win_data;
                    start_nxt = 1'b1;
                end
            end
            START: begin
                cnt_nxt = '0;
            end
            WAIT_LOW: begin
                if (i_tx_done) begin
                    if (timeout_hit) begin
                        // Drop the grant without an ack; the client keeps
                        // requesting and is retried after the others.
                        err_nxt   = 1'b1;
                        grant_nxt = '0;
                        ptr_nxt   = ptr_adv;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
            end
            WAIT_HIGH: begin
                if (i_tx_done) begin
                    ack_nxt   = o_grant;
                    grant_nxt = '0;
                    ptr_nxt   = ptr_adv;
                end
            end
            default: begin
                grant_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter with a small transmitter model: done
// drops one cycle after it samples a start pulse and rises frame_len cycles
// later. A monitor logs starts, acks, errors and done rises with their cycle
// numbers; each scenario then compares those logs against hand-derived
// values.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int NBITS   = 8;
    localparam int TIMEOUT = 16;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       i_req;
    logic [NREQ*NBITS-1:0] i_data;
    logic [NREQ-1:0]       o_ack;
    logic [NREQ-1:0]       o_grant;
    logic                  o_tx_start;
    logic [NBITS-1:0]      o_tx_data;
    logic                  i_tx_done;
    logic                  o_busy;
    logic                  o_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // transmitter model controls
    logic model_done = 1'b1;
    logic hold_low   = 1'b0;
    int   tx_cnt     = 0;
    int   frame_len  = 160;
    int   tx_mode    = 0;      // 0: normal, 1: never accepts a start

    // monitor logs
    int              start_cyc[$];
    logic [NREQ-1:0] start_grant[$];
    logic [7:0]      start_data[$];
    int              ack_cyc[$];
    logic [NREQ-1:0] ack_vec[$];
    logic [7:0]      ack_data[$];
    int              err_cyc[$];
    int              rise_cyc[$];
    logic            prev_done = 1'b1;

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .NBITS   (NBITS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_data     (i_data),
        .o_ack      (o_ack),
        .o_grant    (o_grant),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .i_tx_done  (i_tx_done),
        .o_busy     (o_busy),
        .o_err      (o_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign i_tx_done = model_done & ~hold_low;

    // Cycle counter and transmitter model.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) model_done <= 1'b1;
        end else if (o_tx_start && tx_mode == 0) begin
            model_done <= 1'b0;
            tx_cnt     <= frame_len;
        end
    end

    // Monitor, sampling away from the active edge.
    always @(negedge clk) begin
        if (o_tx_start) begin
            start_cyc.push_back(cyc);
            start_grant.push_back(o_grant);
            start_data.push_back(o_tx_data);
        end
        if (o_ack != '0) begin
            ack_cyc.push_back(cyc);
            ack_vec.push_back(o_ack);
            ack_data.push_back(o_tx_data);
        end
        if (o_err) err_cyc.push_back(cyc);
        if (i_tx_done && !prev_done) rise_cyc.push_back(cyc);
        prev_done <= i_tx_done;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle, landing just after the falling edge so the monitor has
    // already logged that cycle.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int log_size(input int kind);
        case (kind)
            0:       return start_cyc.size();
            1:       return ack_cyc.size();
            default: return err_cyc.size();
        endcase
    endfunction

    // Wait (bounded) until log `kind` holds n entries; a miss is a failure.
    task automatic wait_log(input int kind, input int n, input int bound,
                            input string tag);
        for (int i = 0; i < bound && log_size(kind) < n; i++) tick();
        check(tag, log_size(kind), n);
    endtask

    task automatic clear_logs();
        start_cyc.delete();
        start_grant.delete();
        start_data.delete();
        ack_cyc.delete();
        ack_vec.delete();
        ack_data.delete();
        err_cyc.delete();
        rise_cyc.delete();
    endtask

    task automatic do_reset();
        for (int i = 0; i < 400 && tx_cnt != 0; i++) tick();
        i_req = '0;
        rst   = 1'b1;
        tick();
        tick();
        clear_logs();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int r;
        int d;
        rst    = 1'b0;
        i_req  = '0;
        i_data = '0;
        #2 rst = 1'b1;
        tick();
        tick();

        // ---- reset values ----
        check("rst_ack",   32'(o_ack),      0);
        check("rst_grant", 32'(o_grant),    0);
        check("rst_start", 32'(o_tx_start), 0);
        check("rst_data",  32'(o_tx_data),  0);
        check("rst_busy",  32'(o_busy),     0);
        check("rst_err",   32'(o_err),      0);
        clear_logs();
        rst = 1'b0;
        tick();

        // ---- single byte from client 2 ----
        frame_len = 160;
        i_data    = 32'h00A5_0000;
        i_req     = 4'b0100;
        wait_log(1, 1, 300, "t1_ack_seen");
        i_req = '0;
        check("t1_starts", start_cyc.size(), 1);
        if (start_cyc.size() > 0 && ack_cyc.size() > 0 && rise_cyc.size() > 0) begin
            check("t1_grant",   32'(start_grant[0]), 32'b0100);
            check("t1_data",    32'(start_data[0]),  32'hA5);
            check("t1_ack_vec", 32'(ack_vec[0]),     32'b0100);
            check("t1_ack_lat", ack_cyc[0] - rise_cyc[0], 1);
        end

        // ---- all clients continuously: order 0,1,2,3,0 ----
        do_reset();
        frame_len = 20;
        i_data    = 32'h1312_1110;
        i_req     = 4'b1111;
        wait_log(0, 5, 300, "t2_starts_seen");
        i_req = '0;
        wait_log(1, 5, 100, "t2_acks_seen");
        if (start_cyc.size() >= 5 && ack_cyc.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check($sformatf("t2_grant%0d", k), 32'(start_grant[k]), 32'(1 << (k % 4)));
                check($sformatf("t2_data%0d", k),  32'(start_data[k]),  32'(8'h10 + k % 4));
            end
            for (int k = 0; k < 4; k++) begin
                check($sformatf("t2_ack%0d", k), 32'(ack_vec[k]), 32'(1 << k));
                check($sformatf("t2_gap%0d", k), start_cyc[k+1] - ack_cyc[k], 1);
            end
        end

        // ---- transmitter never accepts: timeout ----
        do_reset();
        tx_mode = 1;
        i_data  = 32'h0000_2211;
        i_req   = 4'b0011;
        wait_log(0, 2, 100, "t3_starts_seen");
        check("t3_err_count", err_cyc.size(), 1);
        check("t3_no_ack",    ack_cyc.size(), 0);
        if (start_cyc.size() >= 2 && err_cyc.size() > 0) begin
            d = err_cyc[0] - start_cyc[0];
            check("t3_err_time", 32'(d >= TIMEOUT - 1 && d <= TIMEOUT + 1), 1);
            check("t3_next_grant", 32'(start_grant[1]), 32'b0010);
            check("t3_regrant_gap", start_cyc[1] - err_cyc[0], 1);
        end
        i_req   = '0;
        tx_mode = 0;
        repeat (40) tick();

        // ---- done held low through reset release ----
        hold_low = 1'b1;
        do_reset();
        i_data = 32'h0000_00C3;
        i_req  = 4'b0001;
        repeat (10) tick();
        check("t4_no_start",   start_cyc.size(), 0);
        check("t4_grant_idle", 32'(o_grant), 0);
        r        = cyc;
        hold_low = 1'b0;
        wait_log(0, 1, 20, "t4_start_seen");
        if (start_cyc.size() > 0) check("t4_start_cyc", start_cyc[0] - r, 1);
        wait_log(1, 1, 60, "t4_ack_seen");
        i_req = '0;

        // ---- reset during WAIT_HIGH ----
        do_reset();
        frame_len = 20;
        i_data    = 32'h7700_0000 | 32'h005A_0000 | 32'h0000_00C3;
        i_req     = 4'b0100;
        wait_log(1, 1, 60, "t5_first_ack");
        i_req = '0;
        tick();
        i_req = 4'b1000;
        wait_log(0, 2, 20, "t5_second_start");
        repeat (5) tick();
        check("t5_busy_before", 32'(o_busy), 1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_grant", 32'(o_grant), 0);
        check("t5_async_outs",
              32'({o_ack, o_tx_start, o_tx_data, o_busy, o_err}), 0);
        tick();
        tick();
        rst   = 1'b0;
        i_req = 4'b1001;
        wait_log(0, 3, 60, "t5_restart_seen");
        check("t5_no_abort_ack", ack_cyc.size(), 1);
        if (start_cyc.size() >= 3 && rise_cyc.size() > 0) begin
            check("t5_ptr_reset", 32'(start_grant[2]), 32'b0001);
            check("t5_wait_done", start_cyc[2] - rise_cyc[rise_cyc.size()-1], 1);
        end
        i_req = '0;
        wait_log(1, 2, 60, "t5_final_ack");

        // ---- data change and request drop after grant ----
        do_reset();
        i_data = 32'h0000_3C00;
        i_req  = 4'b0010;
        wait_log(0, 1, 20, "t6_start_seen");
        tick();
        i_data = 32'hFFFF_FFFF;
        i_req  = '0;
        wait_log(1, 1, 60, "t6_ack_seen");
        if (start_cyc.size() > 0 && ack_cyc.size() > 0) begin
            check("t6_ack_vec",    32'(ack_vec[0]),    32'b0010);
            check("t6_start_data", 32'(start_data[0]), 32'h3C);
            check("t6_ack_data",   32'(ack_data[0]),   32'h3C);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
